// File: rtl/alu_seq_core.sv
// alu_seq_core: sequential 16-bit-class ALU with sticky carry, operand stack and optional iterative mul/div.
// Latency: single-cycle ops return 2 edges after acceptance (accept + execute); mul/div/mod take WIDTH+1 edges.
// Backpressure: in_ready is low from acceptance until the out_valid cycle; requests seen while busy are dropped.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   in_valid/in_ready  request handshake; op, a, b latched on acceptance
//   out_valid          one-cycle pulse when result/flags are updated
//   result             2*WIDTH result, held until the next out_valid
//   flags              {error, stack_empty, stack_full, overflow, sign, zero, carry}
//                      stack_full/stack_empty are live; the rest update with out_valid
//
// Build option: define ALU_MULDIV_EN to include the iterative multiply/divide datapath
// (MUL/DIV states). Without it, ops 5/6/7 complete in one cycle with error=1, result=0.
module alu_seq_core #(
    parameter int WIDTH       = 16,
    parameter int STACK_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [5:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    output logic [2*WIDTH-1:0]   result,
    output logic [6:0]           flags
);

    localparam int SP_W = $clog2(STACK_DEPTH);

    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd2;
    localparam logic [5:0] OP_ADC  = 6'd3;
    localparam logic [5:0] OP_SBB  = 6'd4;
    localparam logic [5:0] OP_MUL  = 6'd5;
    localparam logic [5:0] OP_DIV  = 6'd6;
    localparam logic [5:0] OP_MOD  = 6'd7;
    localparam logic [5:0] OP_NOT  = 6'd9;
    localparam logic [5:0] OP_OR   = 6'd10;
    localparam logic [5:0] OP_AND  = 6'd11;
    localparam logic [5:0] OP_XOR  = 6'd12;
    localparam logic [5:0] OP_NOR  = 6'd13;
    localparam logic [5:0] OP_NAND = 6'd14;
    localparam logic [5:0] OP_XNOR = 6'd15;
    localparam logic [5:0] OP_SHL  = 6'd16;
    localparam logic [5:0] OP_SHR  = 6'd17;
    localparam logic [5:0] OP_CLC  = 6'd24;
    localparam logic [5:0] OP_CMP  = 6'd25;
    localparam logic [5:0] OP_INC  = 6'd26;
    localparam logic [5:0] OP_DEC  = 6'd27;
    localparam logic [5:0] OP_NEG  = 6'd28;
    localparam logic [5:0] OP_PUSH = 6'd29;
    localparam logic [5:0] OP_POP  = 6'd30;
    localparam logic [5:0] OP_CLR  = 6'd33;

    localparam logic [SP_W:0] SP_ONE  = (SP_W+1)'(1);
    localparam logic [SP_W:0] SP_FULL = (SP_W+1)'(STACK_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                 r_state;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic [2*WIDTH-1:0]     r_result;
    logic                   r_err;
    logic                   r_ovf;
    logic                   r_sign;
    logic                   r_zero;
    logic                   r_carry;
    logic [5:0]             r_op;
    logic [WIDTH-1:0]       r_a;
    logic [WIDTH-1:0]       r_b;
    logic [SP_W:0]          r_sp;
    logic [WIDTH-1:0]       r_stack [STACK_DEPTH];

`ifdef ALU_MULDIV_EN
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH-1);

    logic [CNT_W-1:0]       r_cnt;
    logic [2*WIDTH-1:0]     r_acc;      // running product
    logic [2*WIDTH-1:0]     r_mcand;    // multiplicand, shifted left each step
    logic [WIDTH-1:0]       r_mplier;   // multiplier, shifted right each step
    logic [WIDTH-1:0]       r_quo;      // dividend shifts out the top, quotient bits shift in
    logic [WIDTH-1:0]       r_rem;
    logic [WIDTH:0]         w_div_shift;
    logic [WIDTH:0]         w_div_diff;

    // One restoring-division step: bring down the next dividend bit, trial-subtract b.
    assign w_div_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_b};
`endif

    // ------------------------------------------------------------------
    // Stack status
    // ------------------------------------------------------------------
    logic                   w_full;
    logic                   w_empty;
    logic [SP_W:0]          w_sp_dec;
    logic [WIDTH-1:0]       w_top;

    assign w_full   = (r_sp == SP_FULL);
    assign w_empty  = (r_sp == '0);
    assign w_sp_dec = r_sp - SP_ONE;
    assign w_top    = r_stack[w_sp_dec[SP_W-1:0]];

    // ------------------------------------------------------------------
    // Shared adder / subtractor (operands latched at acceptance)
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]       w_add_y;
    logic                   w_add_ci;
    logic [WIDTH-1:0]       w_sub_x;
    logic [WIDTH-1:0]       w_sub_y;
    logic                   w_sub_bi;
    logic [WIDTH:0]         w_sum;
    logic [WIDTH:0]         w_diff;
    logic                   w_add_ovf;
    logic                   w_sub_ovf;

    always_comb begin
        w_add_y  = r_b;
        w_add_ci = 1'b0;
        w_sub_x  = r_a;
        w_sub_y  = r_b;
        w_sub_bi = 1'b0;
        case (r_op)
            OP_ADC:  w_add_ci = r_carry;
            OP_INC:  w_add_y  = WIDTH'(1);
            OP_SBB:  w_sub_bi = r_carry;
            OP_DEC:  w_sub_y  = WIDTH'(1);
            OP_NEG: begin
                w_sub_x = '0;
                w_sub_y = r_a;
            end
            default: ;
        endcase
    end

    assign w_sum  = {1'b0, r_a} + {1'b0, w_add_y} + {{WIDTH{1'b0}}, w_add_ci};
    // Bit WIDTH of the difference is the borrow: it is set exactly when x < y + bi.
    assign w_diff = {1'b0, w_sub_x} - {1'b0, w_sub_y} - {{WIDTH{1'b0}}, w_sub_bi};

    assign w_add_ovf = (r_a[WIDTH-1] == w_add_y[WIDTH-1]) &&
                       (w_sum[WIDTH-1] != r_a[WIDTH-1]);
    assign w_sub_ovf = (w_sub_x[WIDTH-1] != w_sub_y[WIDTH-1]) &&
                       (w_diff[WIDTH-1] != w_sub_x[WIDTH-1]);

    // ------------------------------------------------------------------
    // Completion result and flags, evaluated in S_DONE
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0]     w_a_ext;
    logic [2*WIDTH-1:0]     w_res;
    logic                   w_carry_nxt;
    logic                   w_ovf;
    logic                   w_err;
    logic                   w_is_cmp;
    logic                   w_zero;
    logic                   w_sign;

    assign w_a_ext = {{WIDTH{1'b0}}, r_a};

    always_comb begin
        w_res       = '0;
        w_carry_nxt = r_carry;
        w_ovf       = 1'b0;
        w_err       = 1'b0;
        w_is_cmp    = 1'b0;
        case (r_op)
            OP_ADD, OP_ADC, OP_INC: begin
                w_res       = {{(WIDTH-1){1'b0}}, w_sum};
                w_carry_nxt = w_sum[WIDTH];
                w_ovf       = w_add_ovf;
            end
            OP_SUB, OP_SBB, OP_DEC, OP_NEG: begin
                w_res       = {{WIDTH{1'b0}}, w_diff[WIDTH-1:0]};
                w_carry_nxt = w_diff[WIDTH];
                w_ovf       = w_sub_ovf;
            end
            OP_NOT:  w_res = {{WIDTH{1'b0}}, ~r_a};
            OP_OR:   w_res = {{WIDTH{1'b0}}, r_a | r_b};
            OP_AND:  w_res = {{WIDTH{1'b0}}, r_a & r_b};
            OP_XOR:  w_res = {{WIDTH{1'b0}}, r_a ^ r_b};
            OP_NOR:  w_res = {{WIDTH{1'b0}}, ~(r_a | r_b)};
            OP_NAND: w_res = {{WIDTH{1'b0}}, ~(r_a & r_b)};
            OP_XNOR: w_res = {{WIDTH{1'b0}}, ~(r_a ^ r_b)};
            OP_SHL: begin
                if (r_b < WIDTH'(2*WIDTH)) begin
                    w_res = w_a_ext << r_b;
                end
            end
            OP_SHR: begin
                if (r_b < WIDTH'(WIDTH)) begin
                    w_res = w_a_ext >> r_b;
                end
            end
            OP_CLC:  w_carry_nxt = 1'b0;
            OP_CMP: begin
                w_is_cmp    = 1'b1;
                w_carry_nxt = (r_a < r_b);
            end
            OP_PUSH: w_err = w_full;
            OP_POP: begin
                if (w_empty) begin
                    w_err = 1'b1;
                end else begin
                    w_res = {{WIDTH{1'b0}}, w_top};
                end
            end
            OP_CLR:  ;
`ifdef ALU_MULDIV_EN
            OP_MUL:  w_res = r_acc;
            OP_DIV: begin
                if (r_b == '0) begin
                    w_err = 1'b1;
                end else begin
                    w_res = {{WIDTH{1'b0}}, r_quo};
                end
            end
            OP_MOD: begin
                if (r_b == '0) begin
                    w_err = 1'b1;
                end else begin
                    w_res = {{WIDTH{1'b0}}, r_rem};
                end
            end
`else
            OP_MUL, OP_DIV, OP_MOD: w_err = 1'b1;
`endif
            default: w_err = 1'b1;
        endcase
    end

    // cmp reports the comparison through zero/sign instead of the (zero) result.
    assign w_zero = w_is_cmp ? (r_a == r_b) : (w_res == '0);
    assign w_sign = w_is_cmp ? ($signed(r_a) < $signed(r_b)) : w_res[WIDTH-1];

    // ------------------------------------------------------------------
    // Operand stack storage (contents are never cleared, only the pointer)
    // ------------------------------------------------------------------
    logic w_stack_we;

    assign w_stack_we = (r_state == S_DONE) && (r_op == OP_PUSH) && !w_full && !reset;

    always_ff @(posedge clk) begin
        if (w_stack_we) begin
            r_stack[r_sp[SP_W-1:0]] <= r_a;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_err       <= 1'b0;
            r_ovf       <= 1'b0;
            r_sign      <= 1'b0;
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_sp        <= '0;
`ifdef ALU_MULDIV_EN
            r_cnt       <= '0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_quo       <= '0;
            r_rem       <= '0;
`endif
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_op       <= op;
                        r_a        <= a;
                        r_b        <= b;
                        r_in_ready <= 1'b0;
                        r_state    <= S_DONE;
`ifdef ALU_MULDIV_EN
                        r_cnt    <= '0;
                        r_acc    <= '0;
                        r_mcand  <= {{WIDTH{1'b0}}, a};
                        r_mplier <= b;
                        r_quo    <= a;
                        r_rem    <= '0;
                        if (op == OP_MUL) begin
                            r_state <= S_MUL;
                        end else if ((op == OP_DIV || op == OP_MOD) && b != '0) begin
                            r_state <= S_DIV;
                        end
`endif
                    end
                end
`ifdef ALU_MULDIV_EN
                S_MUL: begin
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= S_DONE;
                    end
                end
                S_DIV: begin
                    if (!w_div_diff[WIDTH]) begin
                        r_rem <= w_div_diff[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                    end else begin
                        r_rem <= w_div_shift[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    r_result    <= w_res;
                    r_err       <= w_err;
                    r_ovf       <= w_ovf;
                    r_sign      <= w_sign;
                    r_zero      <= w_zero;
                    r_carry     <= w_carry_nxt;
                    r_out_valid <= 1'b1;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                    if (r_op == OP_PUSH && !w_full) begin
                        r_sp <= r_sp + SP_ONE;
                    end else if (r_op == OP_POP && !w_empty) begin
                        r_sp <= w_sp_dec;
                    end else if (r_op == OP_CLR) begin
                        r_sp <= '0;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flags     = {r_err, w_empty, w_full, r_ovf, r_sign, r_zero, r_carry};

endmodule

// File: tb/tb_alu_seq_core.sv
// tb_alu_seq_core: directed-vector bench for alu_seq_core (WIDTH=16, STACK_DEPTH=4).
// Latency: checks out_valid timing per op class relative to the acceptance edge.
// Backpressure: issues one request at a time, waiting on out_valid with a cycle bound.
module tb_alu_seq_core;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic [31:0] result;
    logic [6:0]  flags;

    int n_checks;
    int n_fail;

    alu_seq_core #(.WIDTH(16), .STACK_DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .result    (result),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request and wait for its out_valid; cyc = edges after the acceptance edge.
    task automatic do_op(input logic [5:0] o, input logic [15:0] x, input logic [15:0] y,
                         output int cyc);
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!out_valid && cyc < 100);
        n_checks++;
        if (!out_valid) begin
            n_fail++;
            $display("FAIL timeout op=%0d: no out_valid within %0d cycles", o, cyc);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        op = '0;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++;
        if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result); end
        n_checks++;
        if (flags !== 7'b0100000) begin n_fail++; $display("FAIL reset_flags: got %b want 0100000", flags); end
        reset = 1'b0;
    endtask

    task automatic test_add();
        int cyc;
        // Explicit single-cycle timing for the first add.
        in_valid = 1'b1;
        op = 6'd1;
        a = 16'd60000;
        b = 16'd60000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL add_busy: got rdy=%b ov=%b want rdy=0 ov=0", in_ready, out_valid);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL add_done: got ov=%b rdy=%b want ov=1 rdy=1", out_valid, in_ready);
        end
        n_checks++;
        if (result !== 32'h1D4C0) begin n_fail++; $display("FAIL add_result: got %h want 1d4c0", result); end
        n_checks++;
        if (flags[0] !== 1'b1 || flags[3] !== 1'b0) begin
            n_fail++; $display("FAIL add_flags: got c=%b v=%b want c=1 v=0", flags[0], flags[3]);
        end
        // adc consumes the carry left by the add.
        do_op(6'd3, 16'hFFFF, 16'hFFFF, cyc);
        n_checks++;
        if (result !== 32'h1FFFF || flags[0] !== 1'b1) begin
            n_fail++; $display("FAIL adc: got %h c=%b want 1ffff c=1", result, flags[0]);
        end
        do_op(6'd26, 16'h7FFF, 16'h0, cyc);
        n_checks++;
        if (result !== 32'h8000 || flags[3:0] !== 4'b1100) begin
            n_fail++; $display("FAIL inc_ovf: got %h f=%b want 8000 f=1100", result, flags[3:0]);
        end
    endtask

    task automatic test_sub();
        int cyc;
        do_op(6'd2, 16'h0D32, 16'hA012, cyc);
        n_checks++;
        if (result !== 32'h6D20 || flags[0] !== 1'b1 || flags[3] !== 1'b0) begin
            n_fail++; $display("FAIL sub: got %h c=%b v=%b want 6d20 c=1 v=0", result, flags[0], flags[3]);
        end
        do_op(6'd2, 16'hFFFF, 16'hFFFF, cyc);
        n_checks++;
        if (result !== 32'h0 || flags[1] !== 1'b1 || flags[0] !== 1'b0) begin
            n_fail++; $display("FAIL sub_zero: got %h z=%b c=%b want 0 z=1 c=0", result, flags[1], flags[0]);
        end
        do_op(6'd28, 16'h0001, 16'h0, cyc);
        n_checks++;
        if (result !== 32'hFFFF || flags[0] !== 1'b1) begin
            n_fail++; $display("FAIL neg: got %h c=%b want ffff c=1", result, flags[0]);
        end
        do_op(6'd24, 16'h0, 16'h0, cyc);
        n_checks++;
        if (flags[0] !== 1'b0) begin n_fail++; $display("FAIL clc: got c=%b want 0", flags[0]); end
    endtask

    task automatic test_logic_cmp();
        int cyc;
        do_op(6'd12, 16'h00F0, 16'h0FF0, cyc);
        n_checks++;
        if (result !== 32'h0F00) begin n_fail++; $display("FAIL xor: got %h want 0f00", result); end
        do_op(6'd16, 16'h0001, 16'd20, cyc);
        n_checks++;
        if (result !== 32'h0010_0000) begin n_fail++; $display("FAIL shl: got %h want 00100000", result); end
        do_op(6'd16, 16'h0001, 16'd32, cyc);
        n_checks++;
        if (result !== 32'h0) begin n_fail++; $display("FAIL shl_big: got %h want 0", result); end
        do_op(6'd17, 16'h8000, 16'd15, cyc);
        n_checks++;
        if (result !== 32'h1) begin n_fail++; $display("FAIL shr: got %h want 1", result); end
        do_op(6'd25, 16'd3, 16'd5, cyc);
        n_checks++;
        if (result !== 32'h0 || flags[2:0] !== 3'b101) begin
            n_fail++; $display("FAIL cmp_lt: got %h f=%b want 0 f=101", result, flags[2:0]);
        end
        do_op(6'd25, 16'h8000, 16'h0001, cyc);
        n_checks++;
        if (flags[2:0] !== 3'b100) begin n_fail++; $display("FAIL cmp_signed: got f=%b want 100", flags[2:0]); end
    endtask

    task automatic test_muldiv();
        int cyc;
        do_op(6'd1, 16'hFFFF, 16'h0001, cyc);   // sets carry=1 before mul
        do_op(6'd5, 16'hFFFF, 16'hFFFF, cyc);
`ifdef ALU_MULDIV_EN
        n_checks++;
        if (result !== 32'hFFFE0001 || cyc !== 17 || flags[6] !== 1'b0) begin
            n_fail++; $display("FAIL mul: got %h cyc=%0d e=%b want fffe0001 cyc=17 e=0", result, cyc, flags[6]);
        end
`else
        n_checks++;
        if (result !== 32'h0 || cyc !== 1 || flags[6] !== 1'b1 || flags[0] !== 1'b1) begin
            n_fail++; $display("FAIL mul_off: got %h cyc=%0d e=%b c=%b want 0 cyc=1 e=1 c=1", result, cyc, flags[6], flags[0]);
        end
`endif
        do_op(6'd6, 16'd4, 16'd0, cyc);
        n_checks++;
        if (result !== 32'h0 || cyc !== 1 || flags[6] !== 1'b1) begin
            n_fail++; $display("FAIL div0: got %h cyc=%0d e=%b want 0 cyc=1 e=1", result, cyc, flags[6]);
        end
        do_op(6'd7, 16'd2, 16'd3, cyc);
`ifdef ALU_MULDIV_EN
        n_checks++;
        if (result !== 32'h2 || cyc !== 17 || flags[6] !== 1'b0) begin
            n_fail++; $display("FAIL mod: got %h cyc=%0d e=%b want 2 cyc=17 e=0", result, cyc, flags[6]);
        end
        do_op(6'd6, 16'd100, 16'd7, cyc);
        n_checks++;
        if (result !== 32'd14) begin n_fail++; $display("FAIL div: got %h want e", result); end
        do_op(6'd7, 16'd100, 16'd7, cyc);
        n_checks++;
        if (result !== 32'd2) begin n_fail++; $display("FAIL mod2: got %h want 2", result); end
`else
        n_checks++;
        if (result !== 32'h0 || cyc !== 1 || flags[6] !== 1'b1) begin
            n_fail++; $display("FAIL mod_off: got %h cyc=%0d e=%b want 0 cyc=1 e=1", result, cyc, flags[6]);
        end
`endif
    endtask

    task automatic test_stack();
        int cyc;
        logic [15:0] vals [4];
        vals[0] = 16'd5;
        vals[1] = 16'd365;
        vals[2] = 16'd2;
        vals[3] = 16'd7;
        for (int i = 0; i < 4; i++) begin
            do_op(6'd29, vals[i], 16'h0, cyc);
            n_checks++;
            if (flags[6] !== 1'b0) begin n_fail++; $display("FAIL push%0d: got e=%b want 0", i, flags[6]); end
        end
        n_checks++;
        if (flags[5:4] !== 2'b01) begin n_fail++; $display("FAIL stack_full: got %b want 01", flags[5:4]); end
        do_op(6'd29, 16'd9, 16'h0, cyc);
        n_checks++;
        if (flags[6] !== 1'b1 || flags[4] !== 1'b1) begin
            n_fail++; $display("FAIL push_full: got e=%b full=%b want e=1 full=1", flags[6], flags[4]);
        end
        for (int i = 3; i >= 0; i--) begin
            do_op(6'd30, 16'h0, 16'h0, cyc);
            n_checks++;
            if (result !== {16'h0, vals[i]} || flags[6] !== 1'b0) begin
                n_fail++; $display("FAIL pop%0d: got %h e=%b want %h e=0", i, result, flags[6], vals[i]);
            end
        end
        do_op(6'd30, 16'h0, 16'h0, cyc);
        n_checks++;
        if (result !== 32'h0 || flags[6] !== 1'b1 || flags[5] !== 1'b1) begin
            n_fail++; $display("FAIL pop_empty: got %h e=%b empty=%b want 0 e=1 empty=1", result, flags[6], flags[5]);
        end
    endtask

    task automatic test_clear_unknown();
        int cyc;
        do_op(6'd29, 16'd5, 16'h0, cyc);
        n_checks++;
        if (flags[5] !== 1'b0) begin n_fail++; $display("FAIL push_nonempty: got empty=%b want 0", flags[5]); end
        do_op(6'd33, 16'h0, 16'h0, cyc);
        n_checks++;
        if (flags[5] !== 1'b1) begin n_fail++; $display("FAIL clear: got empty=%b want 1", flags[5]); end
        do_op(6'd30, 16'h0, 16'h0, cyc);
        n_checks++;
        if (flags[6] !== 1'b1 || result !== 32'h0) begin
            n_fail++; $display("FAIL pop_after_clear: got %h e=%b want 0 e=1", result, flags[6]);
        end
        do_op(6'd12, 16'h1234, 16'h1234, cyc);  // clears the error bit with a result of 0
        do_op(6'd34, 16'hFFFF, 16'hFFFF, cyc);
        n_checks++;
        if (flags[6] !== 1'b1 || result !== 32'h0) begin
            n_fail++; $display("FAIL unknown_op: got %h e=%b want 0 e=1", result, flags[6]);
        end
    endtask

    task automatic test_reset_mid_mul();
        int cyc;
        int seen;
        do_op(6'd1, 16'hFFFF, 16'h0001, cyc);   // carry=1 so the reset has something to clear
        in_valid = 1'b1;
        op = 6'd5;
        a = 16'hFFFF;
        b = 16'hFFFF;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
`ifdef ALU_MULDIV_EN
        repeat (5) @(posedge clk);
        #1;
`endif
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || flags !== 7'b0100000 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid: got rdy=%b f=%b ov=%b want rdy=1 f=0100000 ov=0", in_ready, flags, out_valid);
        end
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen++;
        end
        n_checks++;
        if (seen !== 0) begin n_fail++; $display("FAIL reset_abort: got %0d out_valid pulses want 0", seen); end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_add();
        test_sub();
        test_logic_cmp();
        test_muldiv();
        test_stack();
        test_clear_unknown();
        test_reset_mid_mul();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq_core.md
# alu_seq_core

Clocked, parameterised successor to the combinational 16-bit ALU. It executes one opcode per request over a valid/ready handshake. Multiply and divide run as iterative multi-cycle operations. A sticky carry register serves the carry/borrow ops, and an internal operand stack of configurable depth is built in. It sits between the instruction sequencer and the register file and keeps the existing 6-bit opcode map.

## Interface
- WIDTH, 16: operand width in bits; must be ≥4.
- STACK_DEPTH, 8: operand-stack entries; a power of two, ≥2.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  core can accept a request (idle).
- op  input  6  opcode.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  one-cycle pulse when result and flags are updated.
- result  output  2*WIDTH  result; held until the next out_valid.
- flags  output  7  [0] carry, [1] zero, [2] sign, [3] overflow, [4] stack_full, [5] stack_empty, [6] error.

## Operation
- States: IDLE, MUL, DIV, DONE. A request is accepted when in_valid && in_ready; a, b and op are latched at acceptance.
- Opcode map:
  - 1 add, 2 sub, 3 adc, 4 sbb.
  - 5 mul, 6 div (quotient), 7 mod (remainder).
  - 9 not a, 10 or, 11 and, 12 xor, 13 nor, 14 nand, 15 xnor.
  - 16 shl, 17 shr, 24 clear carry, 25 cmp, 26 inc, 27 dec, 28 two's-complement negate.
  - 29 push a, 30 pop, 33 clear stack.
  - Any other opcode: error=1, result=0.
- Width rules:
  - add, adc, inc: result = zero-extended WIDTH+1-bit sum; carry = bit WIDTH.
  - sub, sbb, dec, neg: low WIDTH bits hold the difference; carry = borrow.
  - mul: full 2*WIDTH product.
  - Logic ops operate on the low WIDTH bits; the upper half is 0.
  - shl: a<<b within 2*WIDTH; result 0 if b≥2*WIDTH. shr: a>>b; result 0 if b≥WIDTH.
- adc adds the carry register; sbb subtracts it. The carry register changes only on arithmetic ops, cmp and op 24.
- Flags:
  - zero = (result==0). sign = result[WIDTH-1]. overflow = signed WIDTH-bit overflow for add/sub/adc/sbb/inc/dec/neg, 0 otherwise.
  - cmp: result=0; zero=(a==b); carry=(a<b unsigned); sign=(a<b signed).
  - stack_full and stack_empty are live at all times, not only at out_valid.
- Stack:
  - push on full: error=1, no write, stack unchanged.
  - pop on empty: error=1, result=0.
  - pop: result = top entry, zero-extended.
  - clear: empty after completion; stored data is not cleared.
- div or mod with b==0: error=1, result=0, completes in 1 cycle and skips the DIV state.
- error is rewritten on every completion.

## Timing
- Reset: in_ready=1, out_valid=0, result=0, flags=7'b0100000 (stack_empty=1), carry=0, stack empty, state=IDLE.
- Reset mid-operation aborts the operation with no out_valid.
- Single-cycle ops: accepted at edge N; out_valid=1 with the new result and flags after edge N+1. in_ready=0 for exactly one cycle.
- mul: shift-add over WIDTH iterations; out_valid after edge N+WIDTH+1.
- div/mod: restoring division; out_valid after edge N+WIDTH+1.
- in_ready=0 from acceptance until out_valid is asserted. in_ready returns to 1 in the out_valid cycle, so back-to-back requests are accepted every 2 cycles minimum.
- in_valid while in_ready=0 is ignored; nothing is queued.

## Configuration
- ALU_MULDIV_EN defined: ops 5, 6 and 7 are implemented iteratively as above.
- ALU_MULDIV_EN undefined: the MUL/DIV states and datapath are omitted. Ops 5, 6 and 7 complete in 1 cycle with error=1 and result=0, and carry is unchanged.

## Test plan
All scenarios use WIDTH=16 and STACK_DEPTH=4.
- add a=60000, b=60000 -> result=0x1D4C0, carry=1, overflow=0. Then adc a=0xFFFF, b=0xFFFF -> result=0x1FFFF, carry=1.
- sub a=0x0D32, b=0xA012 -> low 16 bits=0x6D20, carry=1, overflow=0. sub 0xFFFF−0xFFFF -> result=0, zero=1, carry=0.
- mul 0xFFFF×0xFFFF -> result=0xFFFE0001 with out_valid exactly 17 cycles after acceptance. div 4/0 -> error=1 after 1 cycle. mod 2%3 -> result=2.
- Push 5, 365, 2, 7, then push 9 -> error=1, stack_full=1. Then pop ×4 -> 7, 2, 365, 5. A fifth pop -> error=1, result=0, stack_empty=1.
- Push 5, clear stack (op 33), pop -> error=1. Unknown op 34 -> error=1, result=0.
- Assert reset in the middle of a mul -> no out_valid is produced. On the next cycle in_ready=1, flags=7'b0100000 and carry=0.
